uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
UART transmitter; the transmit-side counterpart of the UART receiver's bitstream register.
- Accepts a parallel byte over a valid/ready handshake.
- Emits an asynchronous serial frame, LSB first: start bit (0), DATA_BITS data bits, STOP_BITS stop bits (1).
- Bit timing comes from an internal clock divider; line idles high.
- Sits between system logic and the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range >= 2
DATA_BITS, 8, data bits per frame; legal 5..8
STOP_BITS, 1, stop bits per frame; legal 1 or 2

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_BITS  byte to send; sampled only on handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a byte; high only in IDLE
tx  output  1  serial line, registered, idle high
busy  output  1  frame in progress; equals ~tx_ready

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE, tx=1, tx_ready=1, busy=0.
  - Bit counter, baud counter and shift register cleared.
  - A frame in progress is abandoned immediately; no partial resume after release.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, tx_ready=1.
  - Handshake = tx_valid && tx_ready at a rising edge.
  - On handshake: latch tx_data into shift register, clear baud counter, go to START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift register bit 0 for CLKS_PER_BIT cycles per bit, LSB first.
  - After each bit: shift right and increment bit index.
  - After bit DATA_BITS-1: go to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Timing, with the handshake at edge k:
  - tx falls to 0 immediately after edge k.
  - Each bit boundary falls at edge k + n*CLKS_PER_BIT.
  - tx_ready returns high after edge k + (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT.
  - Total frame = (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back: if tx_valid is high in the first IDLE cycle, the next frame's start bit begins one cycle after the previous stop bit ends. That single IDLE cycle (tx=1) is the only permitted inter-frame gap.
- tx_data and tx_valid are ignored while busy; changing tx_data mid-frame does not alter the frame.
- tx_valid may drop without a handshake; no state change results.
- Baud counter:
  - Width ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and wraps; a bit advances on the wrap.
- tx is driven from a flop; no combinational path from inputs to tx.
- tx_ready and busy are decoded from state and carry no additional latency.

Test Plan:
(All scenarios use CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated.)
1. Reset then 50 idle cycles with tx_valid=0 -> tx=1, tx_ready=1, busy=0 throughout.
2. Send 0xA5 -> tx holds 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles total). tx_ready is low for exactly 40 cycles, then high.
3. tx_valid held high with 0x00, then 0xFF presented on the first IDLE cycle after frame 1 ->
   - frame 1 = start + eight 0s + stop;
   - exactly 1 idle-high cycle;
   - frame 2 = start + eight 1s + stop;
   - exactly two handshakes observed.
4. Send 0x3C; change tx_data to 0xFF with tx_valid=1 during DATA -> serial bits still 0,0,1,1,1,1,0,0 LSB first; no second handshake until IDLE.
5. Assert rst_n=0 mid-DATA of 0x55 -> tx=1 and tx_ready=1 asynchronously, before the next clk edge. After release, the line stays idle until a new handshake.
6. STOP_BITS=2, send 0x81 -> stop phase is high for 8 cycles; frame is 44 cycles; tx_ready rises at the handshake edge + 44 cycles.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmitter: valid/ready byte in, LSB-first async frame out.
// Frame = start bit, DATA_BITS data bits, STOP_BITS stop bits.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST =
    IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST =
    IDX_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic                 tx_nxt;
  logic                 wrap;
  logic                 hs;

  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;
  assign wrap     = (cnt == CNT_LAST);
  assign hs       = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
      tx    <= tx_nxt;
    end
  end

  // tx_nxt is the line level for the cycle after this edge,
  // so the line flop already reflects the new bit at each boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wrap ? '0 : cnt + CNT_W'(1);
    idx_nxt   = idx;
    shreg_nxt = shreg;
    tx_nxt    = tx;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        tx_nxt  = 1'b1;
        if (hs) begin
          state_nxt = START;
          shreg_nxt = tx_data;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (wrap) begin
          state_nxt = DATA;
          idx_nxt   = '0;
          tx_nxt    = shreg[0];
        end
      end
      DATA: begin
        if (wrap) begin
          shreg_nxt = shreg >> 1;
          if (idx == DATA_LAST) begin
            state_nxt = STOP;
            idx_nxt   = '0;
            tx_nxt    = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
            tx_nxt  = shreg[1];
          end
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (wrap) begin
          if (idx == STOP_LAST) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule
